// File: rtl/mem_arbiter_fsm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared types and default constants for the fetch/data RAM
//                arbiter: state encoding, word/address types, limits.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    localparam int DEF_ADDR_W       = 32;
    localparam int DEF_DATA_W       = 32;
    localparam int DEF_MAX_D_STREAK = 4;
    localparam int DEF_TIMEOUT      = 255;
    localparam int WDOG_W           = 8;

    typedef logic [DEF_DATA_W-1:0] word_t;
    typedef logic [DEF_ADDR_W-1:0] addr_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        I_ACC = 2'd1,
        D_ACC = 2'd2
    } arb_state_t;

    // True while a RAM access is being driven
    function automatic logic is_access(input arb_state_t s);
        return (s == I_ACC) || (s == D_ACC);
    endfunction

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_arbiter_fsm_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_if
//  Description : Bundle of the fetch port, data port and single-port RAM
//                signals around the arbiter. The slave modport is the
//                arbiter's view; master is the view of requesters + RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_arb_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();

    // Fetch port
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ready;
    logic [DATA_W-1:0] i_rdata;

    // Data port
    logic              d_req;
    logic              d_wen;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ready;
    logic [DATA_W-1:0] d_rdata;

    // Abort indication
    logic              err;

    // RAM side
    logic              ram_ren;
    logic              ram_wen;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_store;
    logic [DATA_W-1:0] ram_load;
    logic              busy_o;

    modport slave (
        input  i_req, i_addr,
        output i_ready, i_rdata,
        input  d_req, d_wen, d_addr, d_wdata,
        output d_ready, d_rdata,
        output err,
        output ram_ren, ram_wen, ram_addr, ram_store,
        input  ram_load, busy_o
    );

    modport master (
        output i_req, i_addr,
        input  i_ready, i_rdata,
        output d_req, d_wen, d_addr, d_wdata,
        input  d_ready, d_rdata,
        input  err,
        input  ram_ren, ram_wen, ram_addr, ram_store,
        output ram_load, busy_o
    );

endinterface : mem_arb_if
`default_nettype wire

// File: rtl/mem_arbiter_fsm_watchdog.sv
`default_nettype none
// ============================================================================
//  Module      : arb_watchdog
//  Description : 8-bit busy-cycle counter. Cleared while no access is in
//                flight, counts access cycles with the RAM busy, and flags
//                expiry on the busy cycle where the count reaches TIMEOUT.
//  Revision    : 1.0 - initial release
// ============================================================================
module arb_watchdog
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  wire  CLK,
    input  wire  nRST,
    input  wire  clr,
    input  wire  busy,
    output logic expire
);

    logic [WDOG_W-1:0] wdog_q;
    logic [WDOG_W-1:0] wdog_d;

    // Next count: clear wins, otherwise count busy cycles and hold at all-ones
    always_comb begin
        wdog_d = wdog_q;
        if (clr) begin
            wdog_d = '0;
        end else if (busy && (wdog_q != {WDOG_W{1'b1}})) begin
            wdog_d = wdog_q + WDOG_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end

    assign expire = busy && !clr && (wdog_q == WDOG_W'(TIMEOUT));

endmodule : arb_watchdog
`default_nettype wire

// File: rtl/mem_arbiter_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_fsm
//  Description : Shares one single-port RAM between the fetch and data ports.
//                Data has priority, bounded by a streak counter so a pending
//                fetch is not starved. Granted requests are latched and the
//                RAM controls are decoded from state + latches only. Ready,
//                err and read data are registered; a watchdog aborts accesses
//                that stay busy too long.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter_fsm
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int MAX_D_STREAK = DEF_MAX_D_STREAK,
    parameter int TIMEOUT      = DEF_TIMEOUT
) (
    input  wire      CLK,
    input  wire      nRST,
    mem_arb_if.slave bus
);

    localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);

    arb_state_t        state_q,  state_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [DATA_W-1:0] wdata_q,  wdata_d;
    logic              wen_q,    wen_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic              i_ready_q, i_ready_d;
    logic              d_ready_q, d_ready_d;
    logic              err_q,    err_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    logic              w_i_elig;
    logic              w_d_elig;
    logic              w_expire;
    logic              w_ram_ren;
    logic              w_ram_wen;
    logic [ADDR_W-1:0] w_ram_addr;
    logic [DATA_W-1:0] w_ram_store;

    // A port that is completing this cycle is still retiring its request
    assign w_i_elig = bus.i_req && !i_ready_q;
    assign w_d_elig = bus.d_req && !d_ready_q;

    arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .CLK    (CLK),
        .nRST   (nRST),
        .clr    (state_q == IDLE),
        .busy   (is_access(state_q) && bus.busy_o),
        .expire (w_expire)
    );

    // Next-state, grant/latch decisions and RAM control decode
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wen_d       = wen_q;
        streak_d    = streak_q;
        i_ready_d   = 1'b0;
        d_ready_d   = 1'b0;
        err_d       = 1'b0;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        w_ram_ren   = 1'b0;
        w_ram_wen   = 1'b0;
        w_ram_addr  = '0;
        w_ram_store = '0;

        case (state_q)
            IDLE: begin
                if (w_d_elig && (!w_i_elig || (streak_q < STREAK_W'(MAX_D_STREAK)))) begin
                    state_d = D_ACC;
                    addr_d  = bus.d_addr;
                    wdata_d = bus.d_wdata;
                    wen_d   = bus.d_wen;
                    // Streak only grows while a fetch is actually waiting
                    if (!w_i_elig) begin
                        streak_d = '0;
                    end else if (streak_q != STREAK_W'(MAX_D_STREAK)) begin
                        streak_d = streak_q + STREAK_W'(1);
                    end
                end else if (w_i_elig) begin
                    state_d  = I_ACC;
                    addr_d   = bus.i_addr;
                    streak_d = '0;
                end
            end

            I_ACC: begin
                w_ram_ren  = 1'b1;
                w_ram_addr = addr_q;
                if (!bus.busy_o) begin
                    i_rdata_d = bus.ram_load;
                    i_ready_d = 1'b1;
                    state_d   = IDLE;
                end else if (w_expire) begin
                    i_ready_d = 1'b1;
                    err_d     = 1'b1;
                    state_d   = IDLE;
                end
            end

            D_ACC: begin
                w_ram_addr  = addr_q;
                w_ram_wen   = wen_q;
                w_ram_ren   = !wen_q;
                w_ram_store = wen_q ? wdata_q : '0;
                if (!bus.busy_o) begin
                    if (!wen_q) begin
                        d_rdata_d = bus.ram_load;
                    end
                    d_ready_d = 1'b1;
                    state_d   = IDLE;
                end else if (w_expire) begin
                    d_ready_d = 1'b1;
                    err_d     = 1'b1;
                    state_d   = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, latched request and registered outputs; reset drops any access
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wen_q     <= 1'b0;
            streak_q  <= '0;
            i_ready_q <= 1'b0;
            d_ready_q <= 1'b0;
            err_q     <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wen_q     <= wen_d;
            streak_q  <= streak_d;
            i_ready_q <= i_ready_d;
            d_ready_q <= d_ready_d;
            err_q     <= err_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign bus.i_ready   = i_ready_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_ready   = d_ready_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.err       = err_q;
    assign bus.ram_ren   = w_ram_ren;
    assign bus.ram_wen   = w_ram_wen;
    assign bus.ram_addr  = w_ram_addr;
    assign bus.ram_store = w_ram_store;

endmodule : mem_arbiter_fsm
`default_nettype wire

// File: tb/tb_mem_arbiter_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter_fsm
//  Description : Self-checking bench for mem_arbiter_fsm: directed scenarios
//                followed by randomized requester/RAM traffic, all compared
//                against a transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter_fsm;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXS = 4;
    localparam int TMO  = 255;

    logic CLK = 1'b0;
    logic nRST;

    int vectors     = 0;
    int miscompares = 0;

    mem_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter_fsm #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .MAX_D_STREAK (MAXS),
        .TIMEOUT      (TMO)
    ) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    // Reference model: one outstanding transaction plus per-port results
    bit          m_act;
    bit          m_is_d;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    bit          m_wen;
    int          m_busy_cnt;
    bit          m_ir, m_dr, m_err;
    logic [31:0] m_irdata, m_drdata;
    int          m_streak;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_act = 0; m_is_d = 0; m_addr = '0; m_wdata = '0; m_wen = 0;
        m_busy_cnt = 0; m_ir = 0; m_dr = 0; m_err = 0;
        m_irdata = '0; m_drdata = '0; m_streak = 0;
    endtask

    // Advance the model by one clock using the inputs present at the edge
    task automatic model_step();
        bit i_el, d_el;
        bit nir, ndr, nerr;
        nir = 0; ndr = 0; nerr = 0;
        if (!m_act) begin
            i_el = bus.i_req && !m_ir;
            d_el = bus.d_req && !m_dr;
            if (d_el && (!i_el || m_streak < MAXS)) begin
                m_act = 1; m_is_d = 1;
                m_addr = bus.d_addr; m_wen = bus.d_wen; m_wdata = bus.d_wdata;
                m_streak = i_el ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
            end else if (i_el) begin
                m_act = 1; m_is_d = 0;
                m_addr = bus.i_addr;
                m_streak = 0;
            end
            m_busy_cnt = 0;
        end else if (!bus.busy_o) begin
            if (!m_is_d) begin
                m_irdata = bus.ram_load; nir = 1;
            end else begin
                if (!m_wen) m_drdata = bus.ram_load;
                ndr = 1;
            end
            m_act = 0;
        end else if (m_busy_cnt == TMO) begin
            nerr = 1;
            if (m_is_d) ndr = 1; else nir = 1;
            m_act = 0;
        end else begin
            m_busy_cnt++;
        end
        m_ir = nir; m_dr = ndr; m_err = nerr;
    endtask

    task automatic check_all();
        logic        e_ren, e_wen;
        logic [31:0] e_addr, e_store;
        e_ren = 0; e_wen = 0; e_addr = '0; e_store = '0;
        if (m_act) begin
            e_addr = m_addr;
            if (!m_is_d) begin
                e_ren = 1;
            end else begin
                e_wen   = m_wen;
                e_ren   = !m_wen;
                e_store = m_wen ? m_wdata : 32'h0;
            end
        end
        chk("i_ready",   64'(bus.i_ready),   64'(m_ir));
        chk("d_ready",   64'(bus.d_ready),   64'(m_dr));
        chk("err",       64'(bus.err),       64'(m_err));
        chk("i_rdata",   64'(bus.i_rdata),   64'(m_irdata));
        chk("d_rdata",   64'(bus.d_rdata),   64'(m_drdata));
        chk("ram_ren",   64'(bus.ram_ren),   64'(e_ren));
        chk("ram_wen",   64'(bus.ram_wen),   64'(e_wen));
        chk("ram_addr",  64'(bus.ram_addr),  64'(e_addr));
        chk("ram_store", 64'(bus.ram_store), 64'(e_store));
        chk("ready_excl", 64'(bus.i_ready & bus.d_ready), 64'(0));
    endtask

    // One clock: check at the falling edge, step the model at the rising edge
    task automatic cyc();
        @(negedge CLK);
        check_all();
        @(posedge CLK);
        if (nRST) model_step(); else model_reset();
        #1;
    endtask

    initial begin
        int n;
        nRST = 1'b1;
        bus.i_req = 0; bus.i_addr = '0;
        bus.d_req = 0; bus.d_wen = 0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.ram_load = '0; bus.busy_o = 0;
        model_reset();
        #1 nRST = 1'b0;
        cyc(); cyc();
        nRST = 1'b1;
        cyc();

        // Single fetch read, no wait states
        bus.i_req = 1; bus.i_addr = 32'h100; bus.ram_load = 32'hDEADBEEF;
        cyc();
        chk("rd_ren_c1",  64'(bus.ram_ren),  64'(1));
        chk("rd_addr_c1", 64'(bus.ram_addr), 64'h100);
        cyc();
        chk("rd_ready_c2", 64'(bus.i_ready), 64'(1));
        chk("rd_data_c2",  64'(bus.i_rdata), 64'hDEADBEEF);
        bus.i_req = 0;
        cyc();

        // Data read to seed d_rdata
        bus.d_req = 1; bus.d_wen = 0; bus.d_addr = 32'h20; bus.ram_load = 32'hCAFEF00D;
        cyc(); cyc();
        chk("dr_ready", 64'(bus.d_ready), 64'(1));
        chk("dr_data",  64'(bus.d_rdata), 64'hCAFEF00D);
        bus.d_req = 0;
        cyc();

        // Write with three busy cycles; d_addr changes mid-access
        bus.d_req = 1; bus.d_wen = 1; bus.d_addr = 32'h40; bus.d_wdata = 32'h1234;
        bus.busy_o = 1; bus.ram_load = 32'h55555555;
        cyc();
        for (int k = 1; k <= 4; k++) begin
            chk("wr_wen",   64'(bus.ram_wen),   64'(1));
            chk("wr_store", 64'(bus.ram_store), 64'h1234);
            chk("wr_addr",  64'(bus.ram_addr),  64'h40);
            if (k == 1) bus.d_addr = 32'h80;
            bus.busy_o = (k < 4);
            cyc();
        end
        chk("wr_ready_c5", 64'(bus.d_ready), 64'(1));
        chk("wr_rdata_kept", 64'(bus.d_rdata), 64'hCAFEF00D);
        bus.d_req = 0;
        cyc();

        // Contention: both ports requesting continuously
        bus.i_req = 1; bus.d_req = 1; bus.d_wen = 0; bus.busy_o = 0;
        for (int c = 0; c < 24; c++) begin
            bus.ram_load = $urandom;
            if (m_ir) bus.i_addr = $urandom;
            if (m_dr) bus.d_addr = $urandom;
            cyc();
        end
        bus.i_req = 0; bus.d_req = 0;
        cyc(); cyc(); cyc();

        // Timeout on a data read with the RAM stuck busy
        bus.d_req = 1; bus.d_wen = 0; bus.d_addr = 32'h300; bus.busy_o = 1;
        cyc();
        n = 0;
        while (!bus.d_ready && n < 400) begin
            cyc();
            n++;
        end
        chk("tmo_cycles", 64'(n), 64'(256));
        chk("tmo_ready",  64'(bus.d_ready), 64'(1));
        chk("tmo_err",    64'(bus.err),     64'(1));
        bus.d_req = 0; bus.busy_o = 0;
        cyc();
        chk("tmo_err_pulse", 64'(bus.err), 64'(0));
        cyc();

        // Reset in the middle of a busy data access
        bus.d_req = 1; bus.d_wen = 0; bus.d_addr = 32'h44; bus.busy_o = 1;
        cyc(); cyc();
        chk("pre_rst_ren", 64'(bus.ram_ren), 64'(1));
        nRST = 1'b0;
        #1;
        model_reset();
        chk("rst_ren",   64'(bus.ram_ren),   64'(0));
        chk("rst_addr",  64'(bus.ram_addr),  64'(0));
        chk("rst_ready", 64'(bus.d_ready),   64'(0));
        chk("rst_rdata", 64'({bus.i_rdata, bus.d_rdata}), 64'(0));
        bus.d_req = 0; bus.busy_o = 0;
        cyc(); cyc();
        nRST = 1'b1;
        for (int c = 0; c < 4; c++) begin
            chk("post_rst_no_ready", 64'(bus.d_ready), 64'(0));
            cyc();
        end

        // Randomized traffic
        for (int c = 0; c < 2500; c++) begin
            if (bus.i_req) begin
                if (m_ir) begin
                    if ($urandom_range(1, 0) == 0) bus.i_req = 0;
                    else bus.i_addr = $urandom;
                end else if ($urandom_range(7, 0) == 0) begin
                    bus.i_addr = $urandom;
                end
            end else if ($urandom_range(2, 0) == 0) begin
                bus.i_req = 1; bus.i_addr = $urandom;
            end
            if (bus.d_req) begin
                if (m_dr) begin
                    if ($urandom_range(1, 0) == 0) begin
                        bus.d_req = 0;
                    end else begin
                        bus.d_addr = $urandom; bus.d_wdata = $urandom;
                        bus.d_wen = 1'($urandom_range(1, 0));
                    end
                end else if ($urandom_range(7, 0) == 0) begin
                    bus.d_addr = $urandom; bus.d_wdata = $urandom;
                end
            end else if ($urandom_range(2, 0) == 0) begin
                bus.d_req = 1; bus.d_addr = $urandom; bus.d_wdata = $urandom;
                bus.d_wen = 1'($urandom_range(1, 0));
            end
            bus.busy_o   = ($urandom_range(2, 0) == 0);
            bus.ram_load = $urandom;
            cyc();
        end
        bus.i_req = 0; bus.d_req = 0; bus.busy_o = 0;
        cyc(); cyc(); cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_mem_arbiter_fsm
`default_nettype wire
